// File: rtl/riscy_io_pkg.sv
// Shared definitions for the RISCY multi-channel GPIO port.
//   reg_sel_e      : register address decoded from REG_SEL
//   DEFAULT_*      : default port geometry
//   ch_sel_width() : width of the channel-select bus for a given channel count
package riscy_io_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_CHANNELS    = 2;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_DIR    = 2'd1,
        REG_STATUS = 2'd2,
        REG_MASK   = 2'd3
    } reg_sel_e;

    // A single channel still gets a 1-bit select so the port never collapses to zero width.
    function automatic int ch_sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/riscy_sync_edge.sv
// Input synchroniser and rising-edge detector for one GPIO channel.
//   CLK, RST : clock, asynchronous active-low reset
//   pin_in   : raw pin levels (asynchronous to CLK)
//   dir      : per-bit direction, 1 = output (edges on output bits are ignored)
//   sync_q   : synchronised pin levels (last synchroniser stage)
//   rise     : one bit per pin, high in the cycle the synchronised level goes 0->1 on an input bit
module riscy_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [WIDTH-1:0] dir,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] rise
);

    // chain_q[0] is the first (metastability-catching) stage, chain_q[SYNC_STAGES-1] the output.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
    logic [WIDTH-1:0]                  prev_q, prev_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], pin_in};
        prev_d  = chain_q[SYNC_STAGES-1];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_q = chain_q[SYNC_STAGES-1];

    // A bit just switched from output to input can still report an edge here if its pin is
    // high; that is intended and not suppressed.
    assign rise = sync_q & ~prev_q & ~dir;

endmodule

// File: rtl/riscy_gpio_port.sv
// Multi-channel bidirectional GPIO port for the RISCY core.
//   CLK, RST : clock (rising edge), asynchronous active-low reset
//   CH_SEL   : channel select; values >= CHANNELS ignore writes and read back 0
//   REG_SEL  : 0=DATA 1=DIR 2=STATUS(write-1-to-clear) 3=MASK
//   WR, RD   : one-cycle write / read strobes
//   WDATA    : write data
//   RDATA    : read data, updated two edges after RD and held until the next read
//   RVALID   : one-cycle pulse qualifying RDATA
//   IRQ      : registered OR of STATUS & MASK over all channels
//   IO       : pins, channel c on IO[c*WIDTH +: WIDTH]; driven from OUT where DIR=1, else z
//
// Register interface: a strobe is taken at the rising edge where it is high. Reads capture
// the pre-edge register contents at that edge, so a read and write in the same cycle
// return the old value. The captured value appears on RDATA with RVALID one edge later.
module riscy_gpio_port
    import riscy_io_pkg::*;
#(
    parameter int  WIDTH       = DEFAULT_WIDTH,
    parameter int  CHANNELS    = DEFAULT_CHANNELS,
    parameter int  SYNC_STAGES = DEFAULT_SYNC_STAGES,
    localparam int CSW         = ch_sel_width(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CSW-1:0]            CH_SEL,
    input  logic [1:0]                REG_SEL,
    input  logic                      WR,
    input  logic                      RD,
    input  logic [WIDTH-1:0]          WDATA,
    output logic [WIDTH-1:0]          RDATA,
    output logic                      RVALID,
    output logic                      IRQ,
    inout  wire  [WIDTH*CHANNELS-1:0] IO
);

    localparam logic [CSW:0] CH_LIMIT = (CSW+1)'(CHANNELS);

    // Register file
    logic [CHANNELS-1:0][WIDTH-1:0] dir_q, dir_d;
    logic [CHANNELS-1:0][WIDTH-1:0] out_q, out_d;
    logic [CHANNELS-1:0][WIDTH-1:0] status_q, status_d;
    logic [CHANNELS-1:0][WIDTH-1:0] mask_q, mask_d;

    // Read pipeline: capture stage then output stage
    logic             rd_pend_q, rd_pend_d;
    logic [WIDTH-1:0] rd_pipe_q, rd_pipe_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             irq_q, irq_d;

    // Per-channel synchronised inputs and edge pulses
    logic [CHANNELS-1:0][WIDTH-1:0] sync_v;
    logic [CHANNELS-1:0][WIDTH-1:0] rise_v;

    logic             ch_valid;
    reg_sel_e         sel_e;
    logic [WIDTH-1:0] rd_mux;

    assign ch_valid = ({1'b0, CH_SEL} < CH_LIMIT);
    assign sel_e    = reg_sel_e'(REG_SEL);

    genvar c, b;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_ch
            riscy_sync_edge #(
                .WIDTH       (WIDTH),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync_edge (
                .CLK    (CLK),
                .RST    (RST),
                .pin_in (IO[c*WIDTH +: WIDTH]),
                .dir    (dir_q[c]),
                .sync_q (sync_v[c]),
                .rise   (rise_v[c])
            );

            for (b = 0; b < WIDTH; b++) begin : g_bit
                assign IO[c*WIDTH + b] = dir_q[c][b] ? out_q[c][b] : 1'bz;
            end
        end
    endgenerate

    // Register writes and status update
    always_comb begin
        dir_d    = dir_q;
        out_d    = out_q;
        mask_d   = mask_q;
        status_d = status_q;
        if (WR && ch_valid) begin
            case (sel_e)
                REG_DATA:   out_d[CH_SEL]    = WDATA;
                REG_DIR:    dir_d[CH_SEL]    = WDATA;
                REG_STATUS: status_d[CH_SEL] = status_q[CH_SEL] & ~WDATA;
                REG_MASK:   mask_d[CH_SEL]   = WDATA;
                default:    ;
            endcase
        end
        // Edge set is applied after the clear so a coincident edge keeps the bit set.
        for (int ch = 0; ch < CHANNELS; ch++) begin
            status_d[ch] = status_d[ch] | rise_v[ch];
        end
    end

    // Read mux: DATA shows the output latch on output bits and the synchronised pin otherwise.
    always_comb begin
        rd_mux = '0;
        if (ch_valid) begin
            case (sel_e)
                REG_DATA:   rd_mux = (dir_q[CH_SEL] & out_q[CH_SEL]) |
                                     (~dir_q[CH_SEL] & sync_v[CH_SEL]);
                REG_DIR:    rd_mux = dir_q[CH_SEL];
                REG_STATUS: rd_mux = status_q[CH_SEL];
                REG_MASK:   rd_mux = mask_q[CH_SEL];
                default:    rd_mux = '0;
            endcase
        end
    end

    always_comb begin
        rd_pend_d = RD;
        rd_pipe_d = RD ? rd_mux : rd_pipe_q;
        rvalid_d  = rd_pend_q;
        rdata_d   = rd_pend_q ? rd_pipe_q : rdata_q;
        irq_d     = |(status_q & mask_q);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dir_q     <= '0;
            out_q     <= '0;
            status_q  <= '0;
            mask_q    <= '0;
            rd_pend_q <= 1'b0;
            rd_pipe_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            status_q  <= status_d;
            mask_q    <= mask_d;
            rd_pend_q <= rd_pend_d;
            rd_pipe_q <= rd_pipe_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            irq_q     <= irq_d;
        end
    end

    assign RDATA  = rdata_q;
    assign RVALID = rvalid_q;
    assign IRQ    = irq_q;

endmodule

// File: tb/tb_riscy_gpio_port.sv
// Bench for riscy_gpio_port (WIDTH=8, CHANNELS=2, SYNC_STAGES=2) plus a CHANNELS=3 instance
// for the out-of-range channel select.
`timescale 1ns/100ps
module tb_riscy_gpio_port;
    import riscy_io_pkg::*;

    localparam int SYNC = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (2 channels) ----------------
    logic [0:0]  ch_sel = '0;
    logic [1:0]  reg_sel = '0;
    logic        wr = 1'b0, rd = 1'b0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        rvalid, irq;
    wire  [15:0] io;
    logic [15:0] tb_val = '0;
    logic [15:0] tb_en = '1;

    for (genvar i = 0; i < 16; i++) begin : g_drv
        assign io[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    riscy_gpio_port #(.WIDTH(8), .CHANNELS(2), .SYNC_STAGES(SYNC)) dut (
        .CLK(clk), .RST(rst), .CH_SEL(ch_sel), .REG_SEL(reg_sel), .WR(wr), .RD(rd),
        .WDATA(wdata), .RDATA(rdata), .RVALID(rvalid), .IRQ(irq), .IO(io)
    );

    // ---------------- DUT (3 channels) ----------------
    logic [1:0]  c3_ch = '0;
    logic [1:0]  c3_sel = '0;
    logic        c3_wr = 1'b0, c3_rd = 1'b0;
    logic [7:0]  c3_wdata = '0;
    logic [7:0]  c3_rdata;
    logic        c3_rvalid, c3_irq;
    wire  [23:0] io3;
    assign io3 = '0;

    riscy_gpio_port #(.WIDTH(8), .CHANNELS(3), .SYNC_STAGES(SYNC)) dut3 (
        .CLK(clk), .RST(rst), .CH_SEL(c3_ch), .REG_SEL(c3_sel), .WR(c3_wr), .RD(c3_rd),
        .WDATA(c3_wdata), .RDATA(c3_rdata), .RVALID(c3_rvalid), .IRQ(c3_irq), .IO(io3)
    );

    // ---------------- reference model ----------------
    logic [7:0]  m_dir[2], m_out[2], m_status[2], m_mask[2];
    logic        m_irq;
    logic [7:0]  m_rdata;
    logic [15:0] hist[$];      // hist[k] = pin levels sampled k+1 edges ago
    logic [7:0]  exp_q[$];     // expected read data, in issue order
    int          due_q[$];     // edge index at which each read must appear
    int          cyc = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_dir[c] = '0; m_out[c] = '0; m_status[c] = '0; m_mask[c] = '0;
        end
        m_irq = 1'b0;
        m_rdata = '0;
        hist.delete();
        for (int k = 0; k <= SYNC; k++) hist.push_back('0);
        exp_q.delete();
        due_q.delete();
    endtask

    // One clock: apply inputs, advance the model, check outputs after the edge.
    task automatic step(input logic w, input logic r, input int c, input logic [1:0] s,
                        input logic [7:0] d);
        logic [15:0] dbus, obus, pins, sync_v, prev_v, rise;
        logic [7:0]  rv;
        logic        irq_next, exp_rv;
        wr = w; rd = r; ch_sel = 1'(c); reg_sel = s; wdata = d;

        dbus   = {m_dir[1], m_dir[0]};
        obus   = {m_out[1], m_out[0]};
        pins   = (dbus & obus) | (~dbus & tb_val);
        sync_v = hist[SYNC-1];
        prev_v = hist[SYNC];
        rise   = sync_v & ~prev_v & ~dbus;

        if (r) begin
            case (s)
                REG_DATA:   rv = (m_dir[c] & m_out[c]) | (~m_dir[c] & sync_v[c*8 +: 8]);
                REG_DIR:    rv = m_dir[c];
                REG_STATUS: rv = m_status[c];
                default:    rv = m_mask[c];
            endcase
            exp_q.push_back(rv);
            due_q.push_back(cyc + 1);
        end
        irq_next = |((m_status[0] & m_mask[0]) | (m_status[1] & m_mask[1]));
        if (w) begin
            case (s)
                REG_DATA:   m_out[c] = d;
                REG_DIR:    m_dir[c] = d;
                REG_STATUS: m_status[c] = m_status[c] & ~d;
                default:    m_mask[c] = d;
            endcase
        end
        m_status[0] = m_status[0] | rise[7:0];
        m_status[1] = m_status[1] | rise[15:8];
        m_irq = irq_next;
        hist.push_front(pins);
        void'(hist.pop_back());

        @(posedge clk);
        #1;
        dbus  = {m_dir[1], m_dir[0]};
        tb_en = ~dbus;
        #1;
        exp_rv = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            exp_rv = 1'b1;
            void'(due_q.pop_front());
            m_rdata = exp_q.pop_front();
        end
        check("rvalid", 16'(rvalid), 16'(exp_rv));
        check("rdata", 16'(rdata), 16'(m_rdata));
        check("irq", 16'(irq), 16'(m_irq));
        check("io_drive", io & dbus, {m_out[1], m_out[0]} & dbus);
        cyc++;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 2'd0, 8'h00);
    endtask

    task automatic rd_reg(input int c, input logic [1:0] s, output logic [7:0] val);
        step(1'b0, 1'b1, c, s, 8'h00);
        step(1'b0, 1'b0, 0, 2'd0, 8'h00);
        val = rdata;
    endtask

    task automatic d3_op(input logic w, input logic r, input logic [1:0] c,
                         input logic [1:0] s, input logic [7:0] d);
        c3_wr = w; c3_rd = r; c3_ch = c; c3_sel = s; c3_wdata = d;
        step(1'b0, 1'b0, 0, 2'd0, 8'h00);
        c3_wr = 1'b0; c3_rd = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] v;
        int op;
        model_reset();
        #50;
        check("rst_rdata", 16'(rdata), 16'h0);
        check("rst_rvalid", 16'(rvalid), 16'h0);
        check("rst_irq", 16'(irq), 16'h0);
        check("rst_io", io, 16'h0);
        #1 rst = 1'b1;

        // Reset values of every register
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 4; s++) begin
                rd_reg(c, 2'(s), v);
                check("rst_reg", 16'(v), 16'h0);
            end
        end

        // Output drive and DATA readback
        step(1'b1, 1'b0, 0, REG_DIR, 8'hFF);
        step(1'b1, 1'b0, 0, REG_DATA, 8'hA5);
        check("t2_io_lo", 16'(io[7:0]), 16'hA5);
        rd_reg(0, REG_DATA, v);
        check("t2_rd_data", 16'(v), 16'hA5);

        // Input synchroniser latency
        tb_val[15:8] = 8'h55;
        idle(1);
        rd_reg(1, REG_DATA, v);
        check("t3_rd_early", 16'(v), 16'h00);
        idle(1);
        rd_reg(1, REG_DATA, v);
        check("t3_rd_sync", 16'(v), 16'h55);

        // Edge capture, IRQ, W1C
        tb_val[15:8] = 8'h00;
        idle(4);
        step(1'b1, 1'b0, 1, REG_STATUS, 8'hFF);
        step(1'b1, 1'b0, 1, REG_MASK, 8'h01);
        idle(3);
        check("t4_irq_idle", 16'(irq), 16'h0);
        tb_val[8] = 1'b1;
        idle(3);
        check("t4_irq_early", 16'(irq), 16'h0);
        idle(1);
        check("t4_irq_set", 16'(irq), 16'h1);
        rd_reg(1, REG_STATUS, v);
        check("t4_status", 16'(v), 16'h01);
        step(1'b1, 1'b0, 1, REG_STATUS, 8'h01);
        check("t4_irq_hold", 16'(irq), 16'h1);
        idle(1);
        check("t4_irq_clr", 16'(irq), 16'h0);
        // Clear coinciding with a new edge
        tb_val[8] = 1'b0;
        idle(4);
        tb_val[8] = 1'b1;
        idle(4);
        check("t4_irq_again", 16'(irq), 16'h1);
        tb_val[8] = 1'b0;
        idle(4);
        tb_val[8] = 1'b1;
        idle(2);
        step(1'b1, 1'b0, 1, REG_STATUS, 8'h01);
        idle(1);
        check("t4_irq_stay", 16'(irq), 16'h1);
        rd_reg(1, REG_STATUS, v);
        check("t4_set_wins", 16'(v), 16'h01);

        // Read and write in the same cycle
        step(1'b1, 1'b1, 0, REG_DATA, 8'h3C);
        idle(1);
        check("t5_rdwr_old", 16'(rdata), 16'hA5);
        check("t5_out_new", 16'(io[7:0]), 16'h3C);

        // Out-of-range channel on the 3-channel instance
        d3_op(1'b1, 1'b0, 2'd2, REG_MASK, 8'h5A);
        d3_op(1'b1, 1'b0, 2'd3, REG_DIR, 8'hFF);
        d3_op(1'b0, 1'b1, 2'd2, REG_MASK, 8'h00);
        check("t5_c3_rv_lat", 16'(c3_rvalid), 16'h0);
        d3_op(1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
        check("t5_c3_mask", 16'(c3_rdata), 16'h5A);
        d3_op(1'b0, 1'b1, 2'd3, REG_DIR, 8'h00);
        d3_op(1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
        check("t5_c3_oor_rv", 16'(c3_rvalid), 16'h1);
        check("t5_c3_oor_rd", 16'(c3_rdata), 16'h00);
        for (int c = 0; c < 3; c++) begin
            d3_op(1'b0, 1'b1, 2'(c), REG_DIR, 8'h00);
            d3_op(1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
            check("t5_c3_dir", 16'(c3_rdata), 16'h00);
        end
        check("t5_c3_irq", 16'(c3_irq), 16'h0);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) tb_val = 16'($urandom());
            op = $urandom_range(0, 9);
            step(op < 3, (op >= 2) && (op < 6), int'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 8'($urandom()));
        end

        // Asynchronous reset with a read in flight
        step(1'b1, 1'b0, 0, REG_DIR, 8'hFF);
        step(1'b1, 1'b0, 0, REG_DATA, 8'hA5);
        step(1'b1, 1'b0, 0, REG_MASK, 8'hFF);
        step(1'b0, 1'b1, 0, REG_DATA, 8'h00);
        #2;
        rst = 1'b0;
        tb_val = '0;
        tb_en = '1;
        #1;
        check("t6_io_rel", io, 16'h0000);
        check("t6_rvalid", 16'(rvalid), 16'h0);
        check("t6_irq", 16'(irq), 16'h0);
        check("t6_rdata", 16'(rdata), 16'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("t6_rv_inrst", 16'(rvalid), 16'h0);
        @(posedge clk);
        cyc += 2;
        #1 rst = 1'b1;
        idle(2);
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 4; s++) begin
                rd_reg(c, 2'(s), v);
                check("t6_reg", 16'(v), 16'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
